// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA timing generator.
// Holds the controller state encoding, line/frame total helpers and the colour-bar lookup.
// Contents: state_t, MAX_RGB_W, htot(), vtot(), bar_color().
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    // Widest pixel bar_color() can build; callers truncate to their own width.
    localparam int MAX_RGB_W = 96;

    function automatic int htot(input int hfp, input int hpulse, input int hbp, input int hdisp);
        return hfp + hpulse + hbp + hdisp;
    endfunction

    function automatic int vtot(input int vfp, input int vpulse, input int vbp, input int vdisp);
        return vfp + vpulse + vbp + vdisp;
    endfunction

    // Bar idx drives R/G/B fully on or off from idx[2]/idx[1]/idx[0]; B sits in the low third.
    function automatic logic [MAX_RGB_W-1:0] bar_color(input logic [2:0] idx, input int rgb_w);
        logic [MAX_RGB_W-1:0] c;
        int comp_w;
        c      = '0;
        comp_w = rgb_w / 3;
        for (int b = 0; b < MAX_RGB_W; b++) begin
            if (b < rgb_w) c[b] = idx[b / comp_w];
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel source handshake plus video output bundle of the timing generator.
// master: pixel source / display side; slave: the timing generator itself.
// Signals: src_data/src_valid/src_ready, hs, vs, blank, rgb, sof.
interface vga_timing_gen_if #(
    parameter int RGB_W = 24
) ();
    logic [RGB_W-1:0] src_data;
    logic             src_valid;
    logic             src_ready;
    logic             hs;
    logic             vs;
    logic             blank;
    logic [RGB_W-1:0] rgb;
    logic             sof;

    modport master (
        output src_data, src_valid,
        input  src_ready, hs, vs, blank, rgb, sof
    );

    modport slave (
        input  src_data, src_valid,
        output src_ready, hs, vs, blank, rgb, sof
    );
endinterface

// File: rtl/vga_axis_cnt.sv
// Horizontal/vertical wrap counter pair; h wraps at HTOT-1 and steps v, v wraps at VTOT-1.
// Latency: counters advance one step per enabled cycle; frame_end_o is combinational.
// Ports: clk_i, rst_i (async high), en_i, hcnt_o, vcnt_o, frame_end_o (last pixel of frame).
module vga_axis_cnt #(
    parameter int  HTOT = 14,
    parameter int  VTOT = 7,
    localparam int HW   = $clog2(HTOT),
    localparam int VW   = $clog2(VTOT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [HW-1:0] hcnt_o,
    output logic [VW-1:0] vcnt_o,
    output logic          frame_end_o
);
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          h_end, v_end;

    assign h_end = (hcnt_q == HW'(HTOT - 1));
    assign v_end = (vcnt_q == VW'(VTOT - 1));

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (en_i) begin
            if (h_end) begin
                hcnt_d = '0;
                vcnt_d = v_end ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o      = hcnt_q;
    assign vcnt_o      = vcnt_q;
    assign frame_end_o = h_end & v_end;
endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator and pixel sink: FP/pulse/BP/active ordering, colour bars, underflow stats.
// Latency: hs/vs/blank/rgb/sof registered, one cycle behind the counter position.
// Backpressure: src_ready only in active region while running and not in pattern mode; never stalls timing.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29,
    parameter int RGB_W  = 24,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int UCNT_W = 16
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst,
    input  logic              en,
    input  logic              pattern_en,
    input  logic              clr_stat,
    vga_timing_gen_if.slave   vif,
    output logic              underflow,
    output logic [UCNT_W-1:0] ucnt,
    output logic              running
);
    localparam int HTOT  = htot(HFP, HPULSE, HBP, HDISP);
    localparam int VTOT  = vtot(VFP, VPULSE, VBP, VDISP);
    localparam int HW    = $clog2(HTOT);
    localparam int VW    = $clog2(VTOT);
    localparam int RW    = HW + 3;
    localparam int H_ACT = HTOT - HDISP;
    localparam int V_ACT = VTOT - VDISP;

    state_t            state_q, state_d;
    logic [HW-1:0]     hcnt, hrel;
    logic [VW-1:0]     vcnt;
    logic              frame_end;
    logic              h_act, v_act, active, h_sync, v_sync;
    logic              src_ready, uf;
    logic [2:0]        bar_idx;
    logic              pat_q, pat_d;
    logic              hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, sof_q, sof_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              uf_q, uf_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;

    assign running = (state_q != IDLE);

    vga_axis_cnt #(.HTOT(HTOT), .VTOT(VTOT)) u_cnt (
        .clk_i       (pixel_clk),
        .rst_i       (pixel_rst),
        .en_i        (running),
        .hcnt_o      (hcnt),
        .vcnt_o      (vcnt),
        .frame_end_o (frame_end)
    );

    // en is only acted on at frame end when leaving STOPPING, so frames are never cut short.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (en) state_d = RUN;
            RUN:      if (!en) state_d = STOPPING;
            STOPPING: if (en) state_d = RUN;
                      else if (frame_end) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign h_act  = (hcnt >= HW'(H_ACT));
    assign v_act  = (vcnt >= VW'(V_ACT));
    assign h_sync = (hcnt >= HW'(HFP)) && (hcnt < HW'(HFP + HPULSE));
    assign v_sync = (vcnt >= VW'(VFP)) && (vcnt < VW'(VFP + VPULSE));
    assign active = running && h_act && v_act;
    assign hrel   = hcnt - HW'(H_ACT);

    assign src_ready = active && !pat_q;
    assign uf        = src_ready && !vif.src_valid;

    // Bar index = floor(hrel*8/HDISP) as a chain of compares against constant multiples of HDISP.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({hrel, 3'b000} >= RW'(k * HDISP)) bar_idx = 3'(k);
        end
    end

    always_comb begin
        // Pattern mode is latched at position (0,0) so a frame never switches source midway.
        pat_d   = (hcnt == '0 && vcnt == '0) ? pattern_en : pat_q;
        hs_d    = (running && h_sync) ? HS_POL : ~HS_POL;
        vs_d    = (running && v_sync) ? VS_POL : ~VS_POL;
        blank_d = active;
        sof_d   = running && (hcnt == HW'(H_ACT)) && (vcnt == VW'(V_ACT));
        rgb_d   = '0;
        if (active) begin
            if (pat_q)              rgb_d = RGB_W'(bar_color(bar_idx, RGB_W));
            else if (vif.src_valid) rgb_d = vif.src_data;
        end
        // Clearing wins over an underflow landing in the same cycle.
        uf_d   = clr_stat ? 1'b0 : (uf_q | uf);
        ucnt_d = ucnt_q;
        if (clr_stat)                               ucnt_d = '0;
        else if (uf && (ucnt_q != {UCNT_W{1'b1}})) ucnt_d = ucnt_q + 1'b1;
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state_q <= IDLE;
            pat_q   <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            sof_q   <= 1'b0;
            rgb_q   <= '0;
            uf_q    <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            sof_q   <= sof_d;
            rgb_q   <= rgb_d;
            uf_q    <= uf_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign vif.src_ready = src_ready;
    assign vif.hs        = hs_q;
    assign vif.vs        = vs_q;
    assign vif.blank     = blank_q;
    assign vif.sof       = sof_q;
    assign vif.rgb       = rgb_q;
    assign underflow     = uf_q;
    assign ucnt          = ucnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a 14x7 total raster (8x4 active).
// DUT A: active-low syncs, 16-bit ucnt. DUT B: active-high syncs, 4-bit ucnt.
// Each scenario task drives stimulus and checks outputs one cycle after the position they reflect.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_en, a_pat, a_clr, a_uf, a_run;
    logic [15:0] a_ucnt;
    logic [23:0] a_data;
    logic        b_rst, b_en, b_pat, b_clr, b_uf, b_run;
    logic [3:0]  b_ucnt;
    logic [23:0] b_data;

    int nchk = 0;
    int nerr = 0;

    logic [23:0] bars [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                              24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

    vga_timing_gen_if #(.RGB_W(24)) ifa ();
    vga_timing_gen_if #(.RGB_W(24)) ifb ();

    vga_timing_gen #(
        .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(3), .HBP(1), .VFP(1), .VPULSE(1), .VBP(1),
        .RGB_W(24), .HS_POL(1'b0), .VS_POL(1'b0), .UCNT_W(16)
    ) dut_a (
        .pixel_clk(clk), .pixel_rst(a_rst), .en(a_en), .pattern_en(a_pat), .clr_stat(a_clr),
        .vif(ifa), .underflow(a_uf), .ucnt(a_ucnt), .running(a_run)
    );

    vga_timing_gen #(
        .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(3), .HBP(1), .VFP(1), .VPULSE(1), .VBP(1),
        .RGB_W(24), .HS_POL(1'b1), .VS_POL(1'b1), .UCNT_W(4)
    ) dut_b (
        .pixel_clk(clk), .pixel_rst(b_rst), .en(b_en), .pattern_en(b_pat), .clr_stat(b_clr),
        .vif(ifb), .underflow(b_uf), .ucnt(b_ucnt), .running(b_run)
    );

    function automatic int ph(input int k);
        return k % 14;
    endfunction

    function automatic int pv(input int k);
        return (k / 14) % 7;
    endfunction

    // One clock: note handshakes before the edge, advance the incrementing sources after it.
    task automatic tick();
        logic fa, fb;
        #1;
        fa = ifa.src_ready & ifa.src_valid;
        fb = ifb.src_ready & ifb.src_valid;
        @(posedge clk);
        #1;
        if (fa) begin a_data = a_data + 24'd1; ifa.src_data = a_data; end
        if (fb) begin b_data = b_data + 24'd1; ifb.src_data = b_data; end
    endtask

    task automatic test_reset();
        nchk++; if (ifa.hs !== 1'b1)      begin nerr++; $display("FAIL reset_a_hs: got %b want 1", ifa.hs); end
        nchk++; if (ifa.vs !== 1'b1)      begin nerr++; $display("FAIL reset_a_vs: got %b want 1", ifa.vs); end
        nchk++; if (ifa.blank !== 1'b0)   begin nerr++; $display("FAIL reset_a_blank: got %b want 0", ifa.blank); end
        nchk++; if (ifa.rgb !== 24'h0)    begin nerr++; $display("FAIL reset_a_rgb: got %h want 0", ifa.rgb); end
        nchk++; if (ifa.sof !== 1'b0)     begin nerr++; $display("FAIL reset_a_sof: got %b want 0", ifa.sof); end
        nchk++; if (a_uf !== 1'b0)        begin nerr++; $display("FAIL reset_a_underflow: got %b want 0", a_uf); end
        nchk++; if (a_ucnt !== 16'd0)     begin nerr++; $display("FAIL reset_a_ucnt: got %0d want 0", a_ucnt); end
        nchk++; if (ifa.src_ready !== 1'b0) begin nerr++; $display("FAIL reset_a_ready: got %b want 0", ifa.src_ready); end
        nchk++; if (a_run !== 1'b0)       begin nerr++; $display("FAIL reset_a_running: got %b want 0", a_run); end
        nchk++; if (ifb.hs !== 1'b0)      begin nerr++; $display("FAIL reset_b_hs: got %b want 0", ifb.hs); end
        nchk++; if (ifb.vs !== 1'b0)      begin nerr++; $display("FAIL reset_b_vs: got %b want 0", ifb.vs); end
        nchk++; if (b_run !== 1'b0)       begin nerr++; $display("FAIL reset_b_running: got %b want 0", b_run); end
    endtask

    task automatic test_stream();
        logic [23:0] exp_pix;
        int h, v, ncons, nsof;
        logic act;
        a_en = 1'b1; ifa.src_valid = 1'b1;
        tick();                                   // first RUN cycle at (0,0)
        exp_pix = a_data; ncons = 0; nsof = 0;
        for (int j = 0; j < 196; j++) begin
            h = ph(j); v = pv(j); act = (h >= 6) && (v >= 3);
            nchk++; if (ifa.src_ready !== act) begin nerr++; $display("FAIL stream_ready j=%0d: got %b want %b", j, ifa.src_ready, act); end
            if (ifa.src_ready) ncons++;
            tick();
            nchk++; if (ifa.hs !== !(h >= 2 && h < 5)) begin nerr++; $display("FAIL stream_hs j=%0d: got %b want %b", j, ifa.hs, !(h >= 2 && h < 5)); end
            nchk++; if (ifa.vs !== !(v == 1)) begin nerr++; $display("FAIL stream_vs j=%0d: got %b want %b", j, ifa.vs, !(v == 1)); end
            nchk++; if (ifa.blank !== act) begin nerr++; $display("FAIL stream_blank j=%0d: got %b want %b", j, ifa.blank, act); end
            nchk++; if (ifa.sof !== (h == 6 && v == 3)) begin nerr++; $display("FAIL stream_sof j=%0d: got %b want %b", j, ifa.sof, (h == 6 && v == 3)); end
            if (act) begin
                nchk++; if (ifa.rgb !== exp_pix) begin nerr++; $display("FAIL stream_rgb j=%0d: got %h want %h", j, ifa.rgb, exp_pix); end
                exp_pix = exp_pix + 24'd1;
            end else begin
                nchk++; if (ifa.rgb !== 24'h0) begin nerr++; $display("FAIL stream_rgb_blank j=%0d: got %h want 0", j, ifa.rgb); end
            end
            if (ifa.sof) nsof++;
        end
        nchk++; if (ncons != 64) begin nerr++; $display("FAIL stream_consumed: got %0d want 64", ncons); end
        nchk++; if (nsof != 2)   begin nerr++; $display("FAIL stream_sof_count: got %0d want 2", nsof); end
        nchk++; if (a_run !== 1'b1) begin nerr++; $display("FAIL stream_running: got %b want 1", a_run); end
    endtask

    task automatic test_underflow();
        logic [23:0] exp_pix;
        int h, v, n;
        logic act, uf, clr_cyc;
        exp_pix = a_data;
        for (int j = 0; j < 196; j++) begin
            h = ph(j); v = pv(j); act = (h >= 6) && (v >= 3);
            n = act ? (v - 3) * 8 + (h - 6) : -1;
            uf = act && ((j < 98 && n >= 10 && n < 15) || (j >= 98 && n == 0));
            clr_cyc = uf && (j >= 98);
            ifa.src_valid = !uf; a_clr = clr_cyc;
            tick();
            a_clr = 1'b0;
            nchk++; if (ifa.blank !== act) begin nerr++; $display("FAIL uf_blank j=%0d: got %b want %b", j, ifa.blank, act); end
            nchk++; if (ifa.hs !== !(h >= 2 && h < 5)) begin nerr++; $display("FAIL uf_hs j=%0d: got %b want %b", j, ifa.hs, !(h >= 2 && h < 5)); end
            if (uf) begin
                nchk++; if (ifa.rgb !== 24'h0) begin nerr++; $display("FAIL uf_black j=%0d: got %h want 0", j, ifa.rgb); end
            end else if (act) begin
                nchk++; if (ifa.rgb !== exp_pix) begin nerr++; $display("FAIL uf_rgb j=%0d: got %h want %h", j, ifa.rgb, exp_pix); end
                exp_pix = exp_pix + 24'd1;
            end
            if (j == 97) begin
                nchk++; if (a_uf !== 1'b1)   begin nerr++; $display("FAIL uf_flag: got %b want 1", a_uf); end
                nchk++; if (a_ucnt !== 16'd5) begin nerr++; $display("FAIL uf_ucnt: got %0d want 5", a_ucnt); end
            end
            if (clr_cyc) begin
                nchk++; if (a_ucnt !== 16'd0) begin nerr++; $display("FAIL clr_prio_ucnt: got %0d want 0", a_ucnt); end
                nchk++; if (a_uf !== 1'b0)    begin nerr++; $display("FAIL clr_prio_flag: got %b want 0", a_uf); end
            end
        end
        nchk++; if (a_ucnt !== 16'd0) begin nerr++; $display("FAIL clr_end_ucnt: got %0d want 0", a_ucnt); end
        ifa.src_valid = 1'b1;
    endtask

    task automatic test_stop();
        int h, v;
        for (int j = 0; j < 98; j++) begin
            h = ph(j); v = pv(j);
            a_en = (j < 56);                      // dropped at (0,4)
            tick();
            nchk++; if (a_run !== (j < 97)) begin nerr++; $display("FAIL stop_running j=%0d: got %b want %b", j, a_run, (j < 97)); end
            nchk++; if (ifa.blank !== (h >= 6 && v >= 3)) begin nerr++; $display("FAIL stop_blank j=%0d: got %b want %b", j, ifa.blank, (h >= 6 && v >= 3)); end
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            nchk++; if (ifa.hs !== 1'b1 || ifa.vs !== 1'b1) begin nerr++; $display("FAIL idle_sync i=%0d: got hs=%b vs=%b want 1 1", i, ifa.hs, ifa.vs); end
            nchk++; if (ifa.blank !== 1'b0 || ifa.src_ready !== 1'b0) begin nerr++; $display("FAIL idle_blank_ready i=%0d: got %b %b want 0 0", i, ifa.blank, ifa.src_ready); end
            nchk++; if (a_run !== 1'b0) begin nerr++; $display("FAIL idle_running i=%0d: got %b want 0", i, a_run); end
        end
        // Restart, then pull en low and back high while STOPPING: frames must stay back to back.
        a_en = 1'b1;
        tick();
        for (int j = 0; j < 196; j++) begin
            a_en = !(j >= 56 && j < 70);
            tick();
            nchk++; if (a_run !== 1'b1) begin nerr++; $display("FAIL rearm_running j=%0d: got %b want 1", j, a_run); end
            nchk++; if (ifa.sof !== (j % 98 == 48)) begin nerr++; $display("FAIL rearm_sof j=%0d: got %b want %b", j, ifa.sof, (j % 98 == 48)); end
        end
        a_en = 1'b0;
        for (int i = 0; i < 98; i++) begin
            tick();
            nchk++; if (a_run !== (i < 97)) begin nerr++; $display("FAIL final_stop i=%0d: got %b want %b", i, a_run, (i < 97)); end
        end
    endtask

    task automatic test_pattern();
        logic [23:0] data0;
        int h, v;
        a_pat = 1'b1;
        tick();
        a_en = 1'b1;
        tick();
        a_en = 1'b0;                              // frame still completes, then IDLE
        data0 = a_data;
        for (int j = 0; j < 98; j++) begin
            h = ph(j); v = pv(j);
            nchk++; if (ifa.src_ready !== 1'b0) begin nerr++; $display("FAIL pat_ready j=%0d: got %b want 0", j, ifa.src_ready); end
            tick();
            if (h >= 6 && v >= 3) begin
                nchk++; if (ifa.rgb !== bars[h - 6]) begin nerr++; $display("FAIL pat_bar j=%0d: got %h want %h", j, ifa.rgb, bars[h - 6]); end
            end else begin
                nchk++; if (ifa.rgb !== 24'h0) begin nerr++; $display("FAIL pat_blank j=%0d: got %h want 0", j, ifa.rgb); end
            end
        end
        nchk++; if (a_data !== data0) begin nerr++; $display("FAIL pat_consumed: got %h want %h", a_data, data0); end
        nchk++; if (a_run !== 1'b0) begin nerr++; $display("FAIL pat_idle: got %b want 0", a_run); end
        a_pat = 1'b0;
        tick();
    endtask

    task automatic test_polarity_reset();
        int h, v;
        b_en = 1'b1; ifb.src_valid = 1'b0;
        tick();
        for (int j = 0; j < 50; j++) begin
            h = ph(j); v = pv(j);
            tick();
            nchk++; if (ifb.hs !== (h >= 2 && h < 5)) begin nerr++; $display("FAIL pol_hs j=%0d: got %b want %b", j, ifb.hs, (h >= 2 && h < 5)); end
            nchk++; if (ifb.vs !== (v == 1)) begin nerr++; $display("FAIL pol_vs j=%0d: got %b want %b", j, ifb.vs, (v == 1)); end
        end
        nchk++; if (b_ucnt !== 4'd2 || b_uf !== 1'b1) begin nerr++; $display("FAIL pre_rst_stats: got ucnt=%0d uf=%b want 2 1", b_ucnt, b_uf); end
        nchk++; if (ifb.blank !== 1'b1) begin nerr++; $display("FAIL pre_rst_blank: got %b want 1", ifb.blank); end
        #2; b_rst = 1'b1; #1;                     // between clock edges
        nchk++; if (ifb.hs !== 1'b0 || ifb.vs !== 1'b0) begin nerr++; $display("FAIL arst_sync: got hs=%b vs=%b want 0 0", ifb.hs, ifb.vs); end
        nchk++; if (ifb.blank !== 1'b0 || ifb.sof !== 1'b0) begin nerr++; $display("FAIL arst_blank_sof: got %b %b want 0 0", ifb.blank, ifb.sof); end
        nchk++; if (ifb.rgb !== 24'h0) begin nerr++; $display("FAIL arst_rgb: got %h want 0", ifb.rgb); end
        nchk++; if (b_ucnt !== 4'd0 || b_uf !== 1'b0) begin nerr++; $display("FAIL arst_stats: got ucnt=%0d uf=%b want 0 0", b_ucnt, b_uf); end
        nchk++; if (b_run !== 1'b0 || ifb.src_ready !== 1'b0) begin nerr++; $display("FAIL arst_run_ready: got %b %b want 0 0", b_run, ifb.src_ready); end
        tick();
        b_rst = 1'b0;
        tick();                                   // restart at (0,0)
        for (int j = 0; j < 6; j++) begin
            tick();
            nchk++; if (ifb.hs !== (j >= 2 && j < 5)) begin nerr++; $display("FAIL restart_hs j=%0d: got %b want %b", j, ifb.hs, (j >= 2 && j < 5)); end
        end
    endtask

    task automatic test_saturate();
        int h, v, n;
        logic act;
        for (int j = 6; j < 98; j++) begin
            h = ph(j); v = pv(j); act = (h >= 6) && (v >= 3);
            n = act ? (v - 3) * 8 + (h - 6) : -1;
            ifb.src_valid = !(act && n < 20);
            tick();
            if (n == 13) begin
                nchk++; if (b_ucnt !== 4'd14) begin nerr++; $display("FAIL sat_ucnt14: got %0d want 14", b_ucnt); end
            end
            if (n == 19) begin
                nchk++; if (b_ucnt !== 4'd15) begin nerr++; $display("FAIL sat_ucnt20: got %0d want 15", b_ucnt); end
            end
        end
        nchk++; if (b_ucnt !== 4'd15) begin nerr++; $display("FAIL sat_final: got %0d want 15", b_ucnt); end
        nchk++; if (b_uf !== 1'b1) begin nerr++; $display("FAIL sat_flag: got %b want 1", b_uf); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_pat = 1'b0; a_clr = 1'b0; a_data = 24'h000001;
        b_rst = 1'b1; b_en = 1'b0; b_pat = 1'b0; b_clr = 1'b0; b_data = 24'h000001;
        ifa.src_valid = 1'b0; ifa.src_data = a_data;
        ifb.src_valid = 1'b0; ifb.src_data = b_data;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        a_rst = 1'b0; b_rst = 1'b0;
        tick();
        test_stream();
        test_underflow();
        test_stop();
        test_pattern();
        test_polarity_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
